// File: rtl/matrix_result_streamer.sv
// -----------------------------------------------------------------------------
// matrix_result_streamer
//
// Streams an M x N FP32 result matrix out of a flat row-major array as a
// valid/ready beat stream, one element per cycle when the sink is ready.
// Row and matrix boundaries are marked with m_row_last / m_last.
//
// Optional feature: define MATRIX_STREAM_RELU_EN to clamp every element whose
// sign bit is set (including -0 and negative NaN) to 32'h00000000 on the way
// out. When undefined, elements are emitted bit-exact.
//
// Ports:
//   clk        single clock, rising edge
//   rst        synchronous active-high reset
//   start      one-cycle job request (from the matrix engine done pulse)
//   M_val      row count of the current result (1..MAX_M)
//   N_val      column count of the current result (1..MAX_N)
//   matrix_C   FP32 elements, element i at bits [32*i +: 32], i = r*N_val+c;
//              read live, so upstream holds it while busy
//   m_valid    stream data valid
//   m_ready    downstream accepts data
//   m_data     FP32 element
//   m_row_last element is last of its row
//   m_last     element is last of the matrix
//   busy       high whenever not IDLE
//   done       one-cycle pulse at end of a job (accepted or rejected)
//   err        set on a rejected job, held until the next accepted start
// -----------------------------------------------------------------------------
module matrix_result_streamer #(
  parameter int MAX_M = 10,
  parameter int MAX_N = 10
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [7:0]                   M_val,
  input  logic [7:0]                   N_val,
  input  logic [32*MAX_M*MAX_N-1:0]    matrix_C,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [31:0]                  m_data,
  output logic                         m_row_last,
  output logic                         m_last,
  output logic                         busy,
  output logic                         done,
  output logic                         err
);

  localparam int DEPTH  = MAX_M * MAX_N;
  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [7:0] MAX_M8 = 8'(MAX_M);
  localparam logic [7:0] MAX_N8 = 8'(MAX_N);

  typedef enum logic [1:0] {IDLE, STREAM, FINISH} state_t;

  state_t state_q, state_d;
  logic [7:0]  row_q, row_d, col_q, col_d;
  logic [7:0]  m_q, m_d, n_q, n_d;
  logic        valid_d, row_last_d, last_d, done_d, err_d;
  logic [31:0] data_d;

  logic [7:0]        row_nx, col_nx;
  logic [ADDR_W-1:0] addr;

  // Word view of the flat input array.
  logic [31:0] elem [DEPTH];
  for (genvar i = 0; i < DEPTH; i++) begin : gen_elem
    assign elem[i] = matrix_C[32*i +: 32];
  end

  function automatic logic [31:0] shape(input logic [31:0] x);
`ifdef MATRIX_STREAM_RELU_EN
    return x[31] ? 32'h0000_0000 : x;
`else
    return x;
`endif
  endfunction

  assign busy = (state_q != IDLE);

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    col_d      = col_q;
    m_d        = m_q;
    n_d        = n_q;
    valid_d    = m_valid;
    data_d     = m_data;
    row_last_d = m_row_last;
    last_d     = m_last;
    done_d     = 1'b0;
    err_d      = err;
    row_nx     = row_q;
    col_nx     = col_q;
    addr       = '0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (M_val == 8'd0 || N_val == 8'd0 || M_val > MAX_M8 || N_val > MAX_N8) begin
            err_d  = 1'b1;
            done_d = 1'b1;
          end else begin
            m_d        = M_val;
            n_d        = N_val;
            row_d      = '0;
            col_d      = '0;
            err_d      = 1'b0;
            data_d     = shape(elem[0]);
            row_last_d = (N_val == 8'd1);
            last_d     = (N_val == 8'd1) && (M_val == 8'd1);
            valid_d    = 1'b1;
            state_d    = STREAM;
          end
        end
      end

      STREAM: begin
        if (m_valid && m_ready) begin
          if (m_last) begin
            valid_d    = 1'b0;
            row_last_d = 1'b0;
            last_d     = 1'b0;
            done_d     = 1'b1;
            state_d    = FINISH;
          end else begin
            // Advance to the next element and load it at the same edge so the
            // stream has no bubbles.
            if (col_q == n_q - 8'd1) begin
              col_nx = '0;
              row_nx = row_q + 8'd1;
            end else begin
              col_nx = col_q + 8'd1;
            end
            addr       = ADDR_W'(row_nx) * ADDR_W'(n_q) + ADDR_W'(col_nx);
            row_d      = row_nx;
            col_d      = col_nx;
            data_d     = shape(elem[addr]);
            row_last_d = (col_nx == n_q - 8'd1);
            last_d     = (row_nx == m_q - 8'd1) && (col_nx == n_q - 8'd1);
          end
        end
      end

      FINISH: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      row_q      <= '0;
      col_q      <= '0;
      m_q        <= '0;
      n_q        <= '0;
      m_valid    <= 1'b0;
      m_data     <= '0;
      m_row_last <= 1'b0;
      m_last     <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      col_q      <= col_d;
      m_q        <= m_d;
      n_q        <= n_d;
      m_valid    <= valid_d;
      m_data     <= data_d;
      m_row_last <= row_last_d;
      m_last     <= last_d;
      done       <= done_d;
      err        <= err_d;
    end
  end

endmodule

// File: tb/tb_matrix_result_streamer.sv
// -----------------------------------------------------------------------------
// Directed self-checking bench for matrix_result_streamer.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the
// falling edge.
// -----------------------------------------------------------------------------
module tb_matrix_result_streamer;

  localparam int MAX_M = 10;
  localparam int MAX_N = 10;
  localparam int DEPTH = MAX_M * MAX_N;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  start;
  logic [7:0]            M_val;
  logic [7:0]            N_val;
  logic [32*DEPTH-1:0]   matrix_C;
  logic                  m_valid;
  logic                  m_ready;
  logic [31:0]           m_data;
  logic                  m_row_last;
  logic                  m_last;
  logic                  busy;
  logic                  done;
  logic                  err;

  int tests = 0;
  int fails = 0;

  logic [31:0] seq6 [6] = '{32'h3F800000, 32'h40000000, 32'h40400000,
                            32'h40800000, 32'h40A00000, 32'h40C00000};

  always #5 clk = ~clk;

  matrix_result_streamer #(.MAX_M(MAX_M), .MAX_N(MAX_N)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .M_val      (M_val),
    .N_val      (N_val),
    .matrix_C   (matrix_C),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_row_last (m_row_last),
    .m_last     (m_last),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_elem(input int idx, input logic [31:0] v);
    matrix_C[32*idx +: 32] = v;
  endtask

  task automatic load_seq6();
    for (int i = 0; i < 6; i++) set_elem(i, seq6[i]);
  endtask

  // Pulses start for one edge; on return the first beat (if any) is visible.
  task automatic start_job(input logic [7:0] m, input logic [7:0] n);
    M_val = m;
    N_val = n;
    start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; M_val = 8'd2; N_val = 8'd3; m_ready = 1'b1;
    matrix_C = '0;
    repeat (3) cycle();
    @(negedge clk);
    tests++;
    if ({m_valid, m_row_last, m_last, busy, done, err} !== 6'b0) begin
      fails++;
      $display("FAIL reset_flags: got v/rl/l/busy/done/err=%b, want 000000",
               {m_valid, m_row_last, m_last, busy, done, err});
    end
    tests++;
    if (m_data !== 32'h0) begin
      fails++;
      $display("FAIL reset_data: got %h, want 00000000", m_data);
    end
    rst = 1'b0; start = 1'b0;
    cycle();
  endtask

  task automatic test_stream_basic();
    load_seq6();
    m_ready = 1'b1;
    start_job(8'd2, 8'd3);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      tests++;
      if (m_data !== seq6[k] ||
          {m_valid, m_row_last, m_last, done} !== {1'b1, (k == 2 || k == 5), (k == 5), 1'b0}) begin
        fails++;
        $display("FAIL basic_beat%0d: got data=%h v/rl/l/done=%b, want data=%h v/rl/l/done=%b",
                 k, m_data, {m_valid, m_row_last, m_last, done},
                 seq6[k], {1'b1, (k == 2 || k == 5), (k == 5), 1'b0});
      end
      cycle();
    end
    @(negedge clk);
    tests++;
    if ({m_valid, done, busy} !== 3'b011) begin
      fails++;
      $display("FAIL basic_done: got v/done/busy=%b, want 011", {m_valid, done, busy});
    end
    cycle();
    @(negedge clk);
    tests++;
    if ({m_valid, done, busy} !== 3'b000) begin
      fails++;
      $display("FAIL basic_idle: got v/done/busy=%b, want 000", {m_valid, done, busy});
    end
    cycle();
  endtask

  // Ready pattern 1,0,0 repeating; start re-pulsed with other dims mid-job.
  task automatic test_backpressure();
    int beats = 0;
    int stab_err = 0;
    int extra = 0;
    bit stalled = 0;
    bit done_seen = 0;
    logic [31:0] prev_data = '0;
    load_seq6();
    m_ready = 1'b1;
    start_job(8'd2, 8'd3);
    for (int cyc = 0; cyc < 60; cyc++) begin
      m_ready = (cyc % 3 == 0);
      if (cyc >= 2 && cyc <= 5) begin
        start = 1'b1; M_val = 8'd5; N_val = 8'd5;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (done) begin
        done_seen = 1;
        break;
      end
      if (m_valid) begin
        if (stalled && m_data !== prev_data) stab_err++;
        if (m_ready) begin
          if (beats < 6) begin
            tests++;
            if (m_data !== seq6[beats] ||
                {m_row_last, m_last} !== {(beats == 2 || beats == 5), (beats == 5)}) begin
              fails++;
              $display("FAIL bp_beat%0d: got data=%h rl/l=%b, want data=%h rl/l=%b",
                       beats, m_data, {m_row_last, m_last}, seq6[beats],
                       {(beats == 2 || beats == 5), (beats == 5)});
            end
          end else begin
            extra++;
          end
          beats++;
          stalled = 0;
        end else begin
          stalled = 1;
          prev_data = m_data;
        end
      end
      cycle();
    end
    start = 1'b0;
    tests++;
    if (beats != 6 || extra != 0) begin
      fails++;
      $display("FAIL bp_count: got %0d beats, want 6", beats);
    end
    tests++;
    if (stab_err != 0) begin
      fails++;
      $display("FAIL bp_stable: got %0d data changes during stall, want 0", stab_err);
    end
    tests++;
    if (!done_seen) begin
      fails++;
      $display("FAIL bp_done: got no done within 60 cycles, want done pulse");
    end
    cycle();
    @(negedge clk);
    tests++;
    if ({m_valid, busy} !== 2'b00) begin
      fails++;
      $display("FAIL bp_idle: got v/busy=%b, want 00", {m_valid, busy});
    end
    cycle();
  endtask

  task automatic test_reject();
    logic [7:0] rm [2] = '{8'd0, 8'd2};
    logic [7:0] rn [2] = '{8'd3, 8'd11};
    for (int t = 0; t < 2; t++) begin
      start_job(rm[t], rn[t]);
      @(negedge clk);
      tests++;
      if ({m_valid, busy, done, err} !== 4'b0011) begin
        fails++;
        $display("FAIL reject%0d_pulse: got v/busy/done/err=%b, want 0011", t,
                 {m_valid, busy, done, err});
      end
      cycle();
      @(negedge clk);
      tests++;
      if ({m_valid, busy, done, err} !== 4'b0001) begin
        fails++;
        $display("FAIL reject%0d_hold: got v/busy/done/err=%b, want 0001", t,
                 {m_valid, busy, done, err});
      end
      cycle();
    end
  endtask

  // 1x1 job held off by m_ready=0 for a cycle; also clears err.
  task automatic test_one_by_one();
    set_elem(0, 32'h12345678);
    m_ready = 1'b0;
    start_job(8'd1, 8'd1);
    @(negedge clk);
    tests++;
    if (m_data !== 32'h12345678 || {m_valid, m_row_last, m_last, err} !== 4'b1110) begin
      fails++;
      $display("FAIL one_first: got data=%h v/rl/l/err=%b, want data=12345678 v/rl/l/err=1110",
               m_data, {m_valid, m_row_last, m_last, err});
    end
    cycle();
    @(negedge clk);
    tests++;
    if (m_data !== 32'h12345678 || {m_valid, m_last, done} !== 3'b110) begin
      fails++;
      $display("FAIL one_stall: got data=%h v/l/done=%b, want data=12345678 v/l/done=110",
               m_data, {m_valid, m_last, done});
    end
    m_ready = 1'b1;
    cycle();
    @(negedge clk);
    tests++;
    if ({m_valid, done, busy} !== 3'b011) begin
      fails++;
      $display("FAIL one_done: got v/done/busy=%b, want 011", {m_valid, done, busy});
    end
    cycle();
  endtask

  task automatic test_reset_mid();
    load_seq6();
    m_ready = 1'b1;
    start_job(8'd2, 8'd3);
    cycle();
    cycle();
    rst = 1'b1;
    start = 1'b1;
    cycle();
    rst = 1'b0;
    start = 1'b0;
    @(negedge clk);
    tests++;
    if ({m_valid, m_row_last, m_last, busy, done, err} !== 6'b0 || m_data !== 32'h0) begin
      fails++;
      $display("FAIL midrst_clear: got data=%h v/rl/l/busy/done/err=%b, want 0 000000",
               m_data, {m_valid, m_row_last, m_last, busy, done, err});
    end
    cycle();
    @(negedge clk);
    tests++;
    if ({m_valid, busy, done} !== 3'b000) begin
      fails++;
      $display("FAIL midrst_nostart: got v/busy/done=%b, want 000", {m_valid, busy, done});
    end
    cycle();
    start_job(8'd2, 8'd3);
    @(negedge clk);
    tests++;
    if (m_data !== 32'h3F800000 || {m_valid, m_row_last, m_last} !== 3'b100) begin
      fails++;
      $display("FAIL midrst_restart: got data=%h v/rl/l=%b, want data=3f800000 v/rl/l=100",
               m_data, {m_valid, m_row_last, m_last});
    end
    repeat (8) cycle();
  endtask

  task automatic test_relu();
    logic [31:0] src [3] = '{32'hBF800000, 32'h3F800000, 32'h80000000};
    logic [31:0] want [3];
`ifdef MATRIX_STREAM_RELU_EN
    want = '{32'h00000000, 32'h3F800000, 32'h00000000};
`else
    want = '{32'hBF800000, 32'h3F800000, 32'h80000000};
`endif
    for (int i = 0; i < 3; i++) set_elem(i, src[i]);
    m_ready = 1'b1;
    start_job(8'd1, 8'd3);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      tests++;
      if (m_data !== want[k] || {m_valid, m_row_last, m_last} !== {1'b1, (k == 2), (k == 2)}) begin
        fails++;
        $display("FAIL relu_beat%0d: got data=%h v/rl/l=%b, want data=%h v/rl/l=%b",
                 k, m_data, {m_valid, m_row_last, m_last}, want[k], {1'b1, (k == 2), (k == 2)});
      end
      cycle();
    end
    @(negedge clk);
    tests++;
    if ({m_valid, done} !== 2'b01) begin
      fails++;
      $display("FAIL relu_done: got v/done=%b, want 01", {m_valid, done});
    end
    cycle();
  endtask

  initial begin
    test_reset();
    test_stream_basic();
    test_backpressure();
    test_reject();
    test_one_by_one();
    test_reset_mid();
    test_relu();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/matrix_result_streamer.md
MATRIX_RESULT_STREAMER -- requirements
Module: matrix_result_streamer

Interface
REQ-001 SHALL have parameter MAX_M, default 10, maximum row count of result matrix.
REQ-002 SHALL have parameter MAX_N, default 10, maximum column count of result matrix.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port start  input  1  one-cycle request to stream result matrix; driven from the matrix engine done pulse.
REQ-006 SHALL have port M_val  input  8  row count of current result.
REQ-007 SHALL have port N_val  input  8  column count of current result.
REQ-008 SHALL have port matrix_C  input  32 x (MAX_M*MAX_N)  FP32 result array, row-major, element (r,c) at index r*N_val+c.
REQ-009 SHALL have port m_valid  output  1  stream data valid.
REQ-010 SHALL have port m_ready  input  1  downstream accepts data.
REQ-011 SHALL have port m_data  output  32  FP32 element.
REQ-012 SHALL have port m_row_last  output  1  current element is last of its row.
REQ-013 SHALL have port m_last  output  1  current element is last of matrix.
REQ-014 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-015 SHALL have port done  output  1  one-cycle pulse at end of a job.
REQ-016 SHALL have port err  output  1  registered; set on rejected job, held until next accepted start.

Function
REQ-017 SHALL implement states IDLE, STREAM, FINISH.
REQ-018 In IDLE with start=1: SHALL latch M_val/N_val, clear row/col counters, clear err, load m_data/m_row_last/m_last for element (0,0), assert m_valid, enter STREAM, all at the same edge; first element visible one cycle after start.
REQ-019 Rejection: start with M_val=0, N_val=0, M_val>MAX_M or N_val>MAX_N SHALL not stream; SHALL set err, pulse done next cycle, remain IDLE.
REQ-020 Transfer occurs on edge where m_valid=1 and m_ready=1; m_data, m_row_last, m_last SHALL stay stable while m_valid=1 and m_ready=0.
REQ-021 On transfer of a non-last element: SHALL load next element at same edge; m_valid stays 1 (zero bubbles, one element per cycle at m_ready=1).
REQ-022 Counter rule: col increments; at col=N-1 col wraps to 0 and row increments; address = row*N+col computed from latched dims, width sufficient for MAX_M*MAX_N-1.
REQ-023 m_row_last SHALL equal (col==N-1); m_last SHALL equal (row==M-1 and col==N-1).
REQ-024 On transfer of the m_last element: m_valid SHALL drop at that edge, state FINISH; in FINISH done=1 for one cycle, then IDLE.
REQ-025 start while busy=1 SHALL be ignored; latched dims unaffected by M_val/N_val changes during a job.
REQ-026 matrix_C is read live per element; upstream SHALL hold it stable while busy=1 (block does not snapshot).
REQ-027 1x1 matrix: single element with m_row_last=1 and m_last=1.

Reset
REQ-028 rst=1 at an edge SHALL force state IDLE, m_valid=0, m_data=0, m_row_last=0, m_last=0, busy=0, done=0, err=0, counters=0, regardless of state; mid-stream jobs are abandoned without done.
REQ-029 start coincident with rst SHALL be ignored.

Configuration
REQ-030 Macro MATRIX_STREAM_RELU_EN defined: every element SHALL be emitted as 32'h00000000 when its sign bit is 1 (including -0 and negative NaN), else unchanged; same latency.
REQ-031 Macro undefined: m_data SHALL equal matrix_C element bit-exactly.

Verification
REQ-032 M=2,N=3, C={1.0..6.0}, m_ready=1: six beats on consecutive cycles, first at start+1; m_row_last on beats 3,6; m_last on beat 6; done pulse one cycle after beat 6.
REQ-033 Same job, m_ready toggling 1,0,0,1,...: data stable during stalls; order 1.0..6.0 preserved; no duplicates or drops.
REQ-034 M=0 or N=11 (MAX 10) start: no m_valid, err=1, done pulse at start+1.
REQ-035 rst asserted after beat 2 of 2x3 job: m_valid=0 next cycle, no done; new start streams from element (0,0).
REQ-036 MATRIX_STREAM_RELU_EN defined, C={32'hBF800000, 32'h3F800000, 32'h80000000}, 1x3: beats 0, 3F800000, 0; undefined: beats bit-exact.
